// File: rtl/mod_counter_pkg.sv
// Shared types and step arithmetic for the programmable modulo counter.
// The step function works on a fixed 32-bit container so one package serves every WIDTH.
package mod_counter_pkg;

  localparam int MAX_W = 32;

  typedef logic [MAX_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    MODE_WRAP     = 2'b00,
    MODE_SAT      = 2'b01,
    MODE_ONESHOT  = 2'b10,
    MODE_WRAP_ALT = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    DIR_NONE = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DOWN = 2'b10
  } dir_e;

  typedef struct packed {
    cnt_t count;
    logic boundary;
    logic running;
  } step_t;

  // Conflicting requests cancel each other: no step and no terminal count.
  function automatic dir_e decode_dir(input logic up, input logic down);
    dir_e dir;
    dir = DIR_NONE;
    if (up && !down) dir = DIR_UP;
    else if (down && !up) dir = DIR_DOWN;
    return dir;
  endfunction

  // me is the effective modulus and is always >= 1, so me-1 never underflows.
  function automatic step_t next_count(input cnt_t count, input cnt_t me, input dir_e dir,
                                       input mode_e mode, input logic running);
    step_t res;
    logic  at_bound;
    res.count    = count;
    res.boundary = 1'b0;
    res.running  = running;
    at_bound     = (dir == DIR_UP) ? (count == me - cnt_t'(1)) : (count == '0);
    if (dir != DIR_NONE && !(mode == MODE_ONESHOT && !running)) begin
      if (at_bound) begin
        res.boundary = 1'b1;
        case (mode)
          MODE_SAT:     res.count = count;
          MODE_ONESHOT: res.running = 1'b0;
          default:      res.count = (dir == DIR_UP) ? '0 : me - cnt_t'(1);
        endcase
      end else begin
        res.count = (dir == DIR_UP) ? count + cnt_t'(1) : count - cnt_t'(1);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mod_counter_prog.sv
// Programmable modulo up/down counter with WRAP/SATURATE/ONESHOT modes,
// terminal-count pulse, sticky overflow flag and compare-match output.
module mod_counter_prog
  import mod_counter_pkg::*;
#(
  parameter int WIDTH       = 12,
  parameter int DEFAULT_MOD = 4000
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_ce,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_data,
  input  logic             i_up,
  input  logic             i_down,
  input  logic [1:0]       i_mode,
  input  logic             i_mod_we,
  input  logic [WIDTH-1:0] i_mod_data,
  input  logic             i_cmp_we,
  input  logic [WIDTH-1:0] i_cmp_data,
  input  logic             i_ovf_clr,
  output logic [WIDTH-1:0] o_count,
  output logic [WIDTH-1:0] o_modulus,
  output logic             o_tc,
  output logic             o_match,
  output logic             o_ovf,
  output logic             o_running
);

  localparam logic [WIDTH-1:0] L_ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] L_DEF_MOD = WIDTH'(DEFAULT_MOD);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_modulus;
  logic [WIDTH-1:0] r_cmp;
  logic             r_tc;
  logic             r_ovf;
  logic             r_running;

  logic [WIDTH-1:0] w_me;
  logic [WIDTH-1:0] w_me_new;
  logic [WIDTH-1:0] w_load_clamped;
  logic [WIDTH-1:0] w_count_next;
  logic [WIDTH-1:0] w_count_final;
  logic             w_running_next;
  logic             w_tc_next;
  dir_e             w_dir;
  mode_e            w_mode;
  step_t            w_step;

  // A zero modulus behaves as modulus 1 so the count is pinned at 0.
  assign w_me     = (r_modulus == '0) ? L_ONE : r_modulus;
  assign w_me_new = (i_mod_data == '0) ? L_ONE : i_mod_data;

  assign w_dir  = decode_dir(i_up, i_down);
  assign w_mode = mode_e'(i_mode);
  assign w_step = next_count(cnt_t'(r_count), cnt_t'(w_me), w_dir, w_mode, r_running);

  assign w_load_clamped = (i_load_data > w_me - L_ONE) ? (w_me - L_ONE) : i_load_data;

  always_comb begin
    w_count_next   = r_count;
    w_running_next = r_running;
    w_tc_next      = 1'b0;
    if (i_ce) begin
      if (i_clr) begin
        w_count_next   = '0;
        w_running_next = 1'b0;
      end else if (i_load) begin
        w_count_next   = w_load_clamped;
        w_running_next = 1'b1;
      end else begin
        w_count_next   = WIDTH'(w_step.count);
        w_running_next = w_step.running;
        w_tc_next      = w_step.boundary;
      end
    end
  end

  // A shrinking modulus folds an out-of-range count back to 0 without a terminal count.
  always_comb begin
    w_count_final = w_count_next;
    if (i_mod_we && (w_count_next >= w_me_new)) w_count_final = '0;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_count   <= '0;
      r_modulus <= L_DEF_MOD;
      r_cmp     <= '0;
      r_tc      <= 1'b0;
      r_ovf     <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_count   <= w_count_final;
      r_running <= w_running_next;
      r_tc      <= w_tc_next;
      if (i_mod_we) r_modulus <= i_mod_data;
      if (i_cmp_we) r_cmp <= i_cmp_data;
      if (w_tc_next) r_ovf <= 1'b1;
      else if (i_ovf_clr) r_ovf <= 1'b0;
    end
  end

  assign o_count   = r_count;
  assign o_modulus = r_modulus;
  assign o_tc      = r_tc;
  assign o_match   = (r_count == r_cmp);
  assign o_ovf     = r_ovf;
  assign o_running = r_running;

endmodule

// File: doc/mod_counter_prog.md
Name: mod_counter_prog

Overview:
- Programmable modulo up/down counter; next generation of the fixed-modulus counter block.
- Adds runtime modulus, three counting modes, terminal-count pulse, sticky overflow flag and compare-match output.
- Used as timer/prescaler/index generator in emulator peripherals; several instances may be chained via o_tc into i_ce.

Parameters:
- WIDTH, 12: counter, modulus and compare width in bits.
- DEFAULT_MOD, 4000: modulus loaded at reset; must satisfy 1 <= DEFAULT_MOD <= 2^WIDTH-1.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_ce  in  1  count/load/clear enable.
- i_clr  in  1  synchronous clear of count (qualified by i_ce).
- i_load  in  1  load count from i_load_data (qualified by i_ce).
- i_load_data  in  WIDTH  load value.
- i_up  in  1  step up request.
- i_down  in  1  step down request.
- i_mode  in  2  00 WRAP, 01 SATURATE, 10 ONESHOT, 11 treated as WRAP.
- i_mod_we  in  1  write modulus (not gated by i_ce).
- i_mod_data  in  WIDTH  new modulus M.
- i_cmp_we  in  1  write compare register (not gated by i_ce).
- i_cmp_data  in  WIDTH  compare value.
- i_ovf_clr  in  1  clear sticky overflow.
- o_count  out  WIDTH  current count.
- o_modulus  out  WIDTH  current modulus.
- o_tc  out  1  terminal-count pulse, one cycle.
- o_match  out  1  o_count == compare register.
- o_ovf  out  1  sticky overflow flag.
- o_running  out  1  ONESHOT active.

Behaviour:
- Reset (async, i_reset_n=0): count=0, modulus=DEFAULT_MOD, compare=0, o_tc=0, o_ovf=0, o_running=0.
- Effective modulus Me = (modulus==0) ? 1 : modulus. Valid count range 0..Me-1.
- Cycle priority when i_ce=1: i_clr > i_load > step. i_ce=0: count, o_running and o_tc (forced 0) hold/clear as stated; modulus and compare writes still take effect.
- i_clr: count<=0; o_running<=0.
- i_load: count <= min(i_load_data, Me-1); o_running<=1.
- Step: dir = up if i_up&~i_down, down if i_down&~i_up, none otherwise (both high = no step, no tc).
- Boundary: up at count==Me-1, or down at count==0.
  - WRAP: up wraps to 0, down wraps to Me-1; o_tc=1.
  - SATURATE: count holds; o_tc=1.
  - ONESHOT: steps only while o_running=1; at boundary count holds, o_running<=0, o_tc=1; no steps or tc while o_running=0.
- Non-boundary step: count +/-1, o_tc=0.
- o_tc: registered, high exactly in the cycle after the boundary-step edge, one cycle wide; 0 on clr/load cycles.
- o_ovf: set on any o_tc event, cleared by i_ovf_clr; set wins when both occur on the same edge.
- Modulus write on the same edge as a step: step uses the old modulus. If the resulting count >= new Me, count<=0 at that edge. No tc is generated.
- Compare write takes effect at the edge. o_match is a combinational compare of registered count and compare value (zero latency after the edge).
- Mode change takes effect on the next step. Mode 11 behaves exactly as WRAP.
- Reset asserted mid-operation returns all state to reset values immediately; first step is allowed on the first edge after deassertion.
- All arithmetic is modulo 2^WIDTH internally, with no overflow beyond Me-1 at any time.

Decomposition:
- Shared package mod_counter_pkg:
  - mode encodings MODE_WRAP, MODE_SAT, MODE_ONESHOT
  - next-count function taking (count, Me, dir, mode, running) and returning next count, boundary flag and next running.
- No sub-module: single flat module. Chaining is done at instantiation level.

Test Plan:
- Reset/defaults: hold i_reset_n=0 for 3 cycles -> o_count=0, o_modulus=4000, o_tc=0, o_ovf=0, o_match=1.
- WRAP up: M=5, mode 00, i_ce=i_up=1 for 6 cycles -> count 1,2,3,4,0,1. o_tc high one cycle after the 4->0 edge. o_ovf=1 thereafter.
- WRAP down and simultaneous: M=5, count=0, i_down -> count 4 with tc. i_up=i_down=1 -> count unchanged, no tc.
- SATURATE/ONESHOT: mode 01, M=3, count=2, i_up x3 -> count stays 2, o_tc pulses each cycle. Mode 10, load 0, i_up x4 -> 1,2,2,2 with single tc and o_running 1->0. Further i_up -> no tc.
- Load clamp and modulus shrink: M=10, load 15 -> count 9. Write M=4 while count=9 -> count 0 next edge. Write M=0 -> count pinned 0, each step gives tc in WRAP.
- Compare and ovf_clr: cmp=3, count up from 0 -> o_match only while count==3. Assert i_ovf_clr on the same edge as a tc -> o_ovf stays 1. Clear on a later edge -> 0.
